ni_rx: RTL and testbench

Receive-side network interface: accepts address/data words arriving from the network router and buffers them in a FIFO. It presents the words to the local core through a first-word-fall-through read port. It is the counterpart of the transmit NI (core write port → network): it sits between the router's ejection port and the core's inbound mailbox, and drives back-pressure toward the router.

---
 rtl/ni_rx_if.sv | 29 ++
 rtl/ni_rx.sv | 138 +++++++++++++
 tb/tb_ni_rx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ni_rx_if.sv
// ni_rx_if - bundle of network-side and core-side signals of the receive NI.
//   master : network router + local core (drives net_w*, core_rinc)
//   slave  : ni_rx (drives net_wfull, core_r*, core_count, drop_cnt)
// Parameters: ADDRSIZE (FIFO pointer width), RSIZE (address/data width).
interface ni_rx_if #(
    parameter int ADDRSIZE = 5,
    parameter int RSIZE    = 16
);
    logic                net_wvalid;
    logic [RSIZE-1:0]    net_wdata;
    logic [RSIZE-1:0]    net_waddr;
    logic                net_wfull;
    logic                core_rinc;
    logic [RSIZE-1:0]    core_rdata;
    logic [RSIZE-1:0]    core_raddr;
    logic                core_rempty;
    logic [ADDRSIZE:0]   core_count;
    logic [7:0]          drop_cnt;

    modport master (
        output net_wvalid, net_wdata, net_waddr, core_rinc,
        input  net_wfull, core_rdata, core_raddr, core_rempty, core_count, drop_cnt
    );

    modport slave (
        input  net_wvalid, net_wdata, net_waddr, core_rinc,
        output net_wfull, core_rdata, core_raddr, core_rempty, core_count, drop_cnt
    );
endinterface

// File: rtl/ni_rx.sv
// ni_rx - receive-side network interface.
// Buffers {addr,data} words from the router ejection port in a 2^ADDRSIZE
// entry memory followed by a single output register, and presents them to
// the core as a first-word-fall-through read port.
// Ports:
//   clk    - single clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - ni_rx_if.slave: net_wvalid/net_wdata/net_waddr/net_wfull toward
//            the router; core_rinc/core_rdata/core_raddr/core_rempty/
//            core_count/drop_cnt toward the core
// Optional feature macro: NI_RX_DROP_CNT_EN enables the saturating count of
// words refused because of back-pressure; otherwise drop_cnt reads 0.
//
// Output stage FSM:
//   state    | meaning
//   ST_EMPTY | output register holds nothing, core_rempty=1
//   ST_VALID | output register holds the head word, core_rempty=0
module ni_rx #(
    parameter int ADDRSIZE = 5,
    parameter int MSB_SLOT = 5
) (
    input  logic   clk,
    input  logic   reset,
    ni_rx_if.slave bus
);
    localparam int DSIZE = 1 << MSB_SLOT;
    localparam int RSIZE = 1 << (MSB_SLOT - 1);
    localparam int DEPTH = 1 << ADDRSIZE;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    logic [DSIZE-1:0]  mem [DEPTH];
    logic [ADDRSIZE:0] wptr;
    logic [ADDRSIZE:0] rptr;
    logic              mem_empty;
    logic              mem_full;
    logic              wr_en;
    logic              load;
    logic [DSIZE-1:0]  head;
    logic [RSIZE-1:0]  rdata_q;
    logic [RSIZE-1:0]  raddr_q;
    state_t            state;
    state_t            state_nxt;

    assign mem_empty = (wptr == rptr);
    assign mem_full  = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                       (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
    assign wr_en     = bus.net_wvalid && !mem_full;
    assign head      = mem[rptr[ADDRSIZE-1:0]];

    // Storage needs no reset: entries are only read between rptr and wptr.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[ADDRSIZE-1:0]] <= {bus.net_waddr, bus.net_wdata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
        end else if (wr_en) begin
            wptr <= wptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // mem_empty comes from registered pointers, so a word written at an edge
    // can only reach the output register at the following edge (no bypass).
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (!mem_empty) begin
                    load      = 1'b1;
                    state_nxt = ST_VALID;
                end
            end
            ST_VALID: begin
                if (bus.core_rinc) begin
                    if (!mem_empty) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr    <= '0;
            rdata_q <= '0;
            raddr_q <= '0;
        end else if (load) begin
            rptr    <= rptr + 1'b1;
            raddr_q <= head[DSIZE-1:RSIZE];
            rdata_q <= head[RSIZE-1:0];
        end
    end

    assign bus.net_wfull   = mem_full;
    assign bus.core_rdata  = rdata_q;
    assign bus.core_raddr  = raddr_q;
    assign bus.core_rempty = (state == ST_EMPTY);
    // Occupancy derives from registered state, so it moves on the same edge
    // as the write/pop that causes it and a simultaneous write+pop cancels.
    assign bus.core_count  = (wptr - rptr) + {{ADDRSIZE{1'b0}}, (state == ST_VALID)};

`ifdef NI_RX_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= 8'd0;
        end else if (bus.net_wvalid && mem_full && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ni_rx.sv
// tb_ni_rx - randomized, self-checking bench for ni_rx against a queue model.
module tb_ni_rx;
    localparam int A     = 5;
    localparam int RS    = 16;
    localparam int DEPTH = 1 << A;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ni_rx_if #(.ADDRSIZE(A), .RSIZE(RS)) bus ();

    ni_rx #(.ADDRSIZE(A), .MSB_SLOT(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: words waiting behind the core port, plus the word on it.
    logic [31:0] mem_q [$];
    logic        out_v;
    logic [31:0] out_w;
    int          drops;
    int          delivered;
    logic        saw_cccc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        out_v = 1'b0;
        out_w = '0;
        drops = 0;
    endtask

    task automatic check_all();
        int exp_drop;
`ifdef NI_RX_DROP_CNT_EN
        exp_drop = drops;
`else
        exp_drop = 0;
`endif
        chk("rempty", 32'(bus.core_rempty), 32'(!out_v));
        if (out_v) begin
            chk("rdata", 32'(bus.core_rdata), 32'(out_w[15:0]));
            chk("raddr", 32'(bus.core_raddr), 32'(out_w[31:16]));
        end
        chk("wfull", 32'(bus.net_wfull), 32'(mem_q.size() == DEPTH));
        chk("count", 32'(bus.core_count), 32'(mem_q.size() + int'(out_v)));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(exp_drop));
        if (!bus.core_rempty && bus.core_rdata == 16'hCCCC) saw_cccc = 1'b1;
    endtask

    task automatic step(input logic wv, input logic [15:0] wd, input logic [15:0] wa,
                        input logic rinc, output logic acc);
        logic full;
        logic pop;
        bus.net_wvalid = wv;
        bus.net_wdata  = wd;
        bus.net_waddr  = wa;
        bus.core_rinc  = rinc;
        @(posedge clk);
        full = (mem_q.size() == DEPTH);
        acc  = wv && !full;
        pop  = rinc && out_v;
        if (pop) delivered++;
        if (!out_v || pop) begin
            if (mem_q.size() > 0) begin
                out_w = mem_q.pop_front();
                out_v = 1'b1;
            end else begin
                out_v = 1'b0;
            end
        end
        if (acc) mem_q.push_back({wa, wd});
        if (wv && full && drops < 255) drops++;
        #1;
        check_all();
    endtask

    task automatic drain();
        logic acc;
        int   guard = 0;
        while ((out_v || mem_q.size() > 0) && guard < 200) begin
            step(1'b0, 16'h0, 16'h0, 1'b1, acc);
            guard++;
        end
        chk("drain_done", 32'(out_v || mem_q.size() > 0), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wfull"},  32'(bus.net_wfull),   32'd0);
        chk({tag, "_rempty"}, 32'(bus.core_rempty), 32'd1);
        chk({tag, "_rdata"},  32'(bus.core_rdata),  32'd0);
        chk({tag, "_raddr"},  32'(bus.core_raddr),  32'd0);
        chk({tag, "_count"},  32'(bus.core_count),  32'd0);
        chk({tag, "_drop"},   32'(bus.drop_cnt),    32'd0);
    endtask

    initial begin
        logic acc;
        int   d0;
        int   sent;
        int   cyc;

        model_reset();
        delivered = 0;
        saw_cccc  = 1'b0;

        // Reset held with random activity on the inputs.
        repeat (2) begin
            bus.net_wvalid = 1'($urandom);
            bus.net_wdata  = 16'($urandom);
            bus.net_waddr  = 16'($urandom);
            bus.core_rinc  = 1'($urandom);
            @(posedge clk);
        end
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b1;

        // Single word.
        step(1'b1, 16'hAAAA, 16'hBBBB, 1'b0, acc);
        chk("single_empty_k", 32'(bus.core_rempty), 32'd1);
        step(1'b0, 16'h0, 16'h0, 1'b0, acc);
        chk("single_rdata", 32'(bus.core_rdata), 32'hAAAA);
        chk("single_raddr", 32'(bus.core_raddr), 32'hBBBB);
        chk("single_count", 32'(bus.core_count), 32'd1);
        step(1'b0, 16'h0, 16'h0, 1'b1, acc);
        chk("single_pop_empty", 32'(bus.core_rempty), 32'd1);
        chk("single_pop_count", 32'(bus.core_count), 32'd0);

        // Fill to capacity and overflow.
        for (int i = 1; i <= 33; i++) begin
            step(1'b1, 16'(16'h1000 + i), 16'(16'h2000 + i), 1'b0, acc);
        end
        chk("fill_wfull", 32'(bus.net_wfull), 32'd1);
        chk("fill_count", 32'(bus.core_count), 32'd33);
        step(1'b1, 16'hCCCC, 16'hBABA, 1'b0, acc);
        chk("ovf_refused", 32'(acc), 32'd0);
`ifdef NI_RX_DROP_CNT_EN
        chk("ovf_drop", 32'(bus.drop_cnt), 32'd1);
`else
        chk("ovf_drop", 32'(bus.drop_cnt), 32'd0);
`endif
        d0 = delivered;
        drain();
        chk("fill_drained", 32'(delivered - d0), 32'd33);
        chk("no_cccc", 32'(saw_cccc), 32'd0);

        // Simultaneous write and pop at a steady depth of 10.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'(16'h3000 + i), 16'(16'h4000 + i), 1'b0, acc);
        end
        for (int i = 10; i < 30; i++) begin
            step(1'b1, 16'(16'h3000 + i), 16'(16'h4000 + i), 1'b1, acc);
            chk("simul_count", 32'(bus.core_count), 32'd10);
        end
        drain();

        // Reset between edges with 10 words held.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'(16'h5000 + i), 16'(16'h6000 + i), 1'b0, acc);
        end
        bus.net_wvalid = 1'b0;
        bus.core_rinc  = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        d0 = delivered;
        step(1'b1, 16'hABBA, 16'hBCCB, 1'b0, acc);
        step(1'b0, 16'h0, 16'h0, 1'b0, acc);
        chk("midrst_rdata", 32'(bus.core_rdata), 32'hABBA);
        chk("midrst_raddr", 32'(bus.core_raddr), 32'hBCCB);
        step(1'b0, 16'h0, 16'h0, 1'b1, acc);
        repeat (3) step(1'b0, 16'h0, 16'h0, 1'b1, acc);
        chk("midrst_only_one", 32'(delivered - d0), 32'd1);

        // Random streaming across pointer wrap.
        d0   = delivered;
        sent = 0;
        cyc  = 0;
        while ((sent < 100 || out_v || mem_q.size() > 0) && cyc < 3000) begin
            step((sent < 100) && ($urandom_range(0, 3) != 0), 16'(sent), 16'(16'h8000 + sent),
                 ($urandom_range(0, 2) == 0), acc);
            if (acc) sent++;
            cyc++;
        end
        chk("wrap_timeout", 32'(cyc < 3000), 32'd1);
        chk("wrap_delivered", 32'(delivered - d0), 32'd100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
